// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port word memory behind a req/ready/ack handshake with a fixed,
//   parameterised response latency. One access is in flight at a time.
//
//   Parameters
//     DEPTH_WORDS : number of 32-bit words (power of two, 4..1024)
//     LATENCY     : wait cycles between acceptance and response (0..15)
//
//   Ports
//     clk        : rising-edge clock
//     rst_n      : asynchronous active-low reset
//     Mem_req    : initiator requests an access
//     Mem_w      : 1 = write, 0 = read
//     Mem_addr   : byte address
//     Mem_w_data : write data
//     Mem_ready  : high while a new request can be accepted
//     Mem_ack    : one-cycle completion pulse
//     Mem_r_data : read data, valid from the ack cycle until the next ack
//     Mem_err    : access was illegal (misaligned or out of range), with ack
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_req,
  input  logic        Mem_w,
  input  logic [31:0] Mem_addr,
  input  logic [31:0] Mem_w_data,
  output logic        Mem_ready,
  output logic        Mem_ack,
  output logic [31:0] Mem_r_data,
  output logic        Mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;

  logic        req_w;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] r_data_q;

  logic          accept;
  logic          legal;
  logic [AW-1:0] idx;
  logic [31:0]   read_word;

  assign accept = Mem_req && (state == IDLE);

  // Legality is judged on the captured request, so it stays stable for the
  // whole transaction regardless of what the initiator drives meanwhile.
  assign legal = (req_addr[1:0] == 2'b00) &&
                 ({2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS));
  assign idx       = req_addr[AW+1:2];
  assign read_word = legal ? mem[idx] : 32'd0;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_next   = 4'(LATENCY);
          state_next = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Leave on the cycle the counter reaches zero, so the ack cycle is
        // the (LATENCY+1)-th cycle after the acceptance edge.
        cnt_next = cnt - 4'd1;
        if (cnt_next == 4'd0) state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // ---- control state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      r_data_q <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      // Latch the read result as RESP ends so it holds until the next ack.
      if (state == RESP && !req_w) r_data_q <= read_word;
    end
  end

  // ---- request capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      req_w     <= Mem_w;
      req_addr  <= Mem_addr;
      req_wdata <= Mem_w_data;
    end
  end

  // ---- storage ----
  // The write commits on the edge ending RESP; rst_n gates it so a reset
  // held across that edge discards the pending write.
  always_ff @(posedge clk) begin
    if (rst_n && state == RESP && req_w && legal) mem[idx] <= req_wdata;
  end

  assign Mem_ready  = (state == IDLE);
  assign Mem_ack    = (state == RESP);
  assign Mem_err    = (state == RESP) && !legal;
  assign Mem_r_data = (state == RESP && !req_w) ? read_word : r_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Index 0: LATENCY=0 instance, index 1: LATENCY=2 instance.
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .Mem_req(req[0]), .Mem_w(wr[0]), .Mem_addr(addr[0]), .Mem_w_data(wdata[0]),
    .Mem_ready(ready[0]), .Mem_ack(ack[0]), .Mem_r_data(rdata[0]), .Mem_err(err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .Mem_req(req[1]), .Mem_w(wr[1]), .Mem_addr(addr[1]), .Mem_w_data(wdata[1]),
    .Mem_ready(ready[1]), .Mem_ack(ack[1]), .Mem_r_data(rdata[1]), .Mem_err(err[1])
  );

  always #5 clk = ~clk;

  // Reference model: memory image, written-flag, last returned read data.
  logic [31:0] mdl    [2][DEPTH];
  bit          known  [2][DEPTH];
  logic [31:0] last_r [2];
  bit          last_k [2];

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nwait;
    logic        rdy_ack;
    logic        ack_after;
    logic        err_after;
    logic [31:0] rd_after;
  } obs_t;

  function automatic int lat_of(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      last_r[s] = 32'd0;
      last_k[s] = 1'b1;
    end
  endtask

  task automatic model_step(input int s, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] e_rd,
                            output logic e_err, output bit e_known);
    logic lg;
    int   wi;
    lg = (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH));
    wi = int'(a >> 2);
    e_err = !lg;
    if (w) begin
      e_rd    = last_r[s];
      e_known = last_k[s];
      if (lg) begin
        mdl[s][wi]   = d;
        known[s][wi] = 1'b1;
      end
    end else begin
      if (lg) begin
        e_rd    = mdl[s][wi];
        e_known = known[s][wi];
      end else begin
        e_rd    = 32'd0;
        e_known = 1'b1;
      end
      last_r[s] = e_rd;
      last_k[s] = e_known;
    end
  endtask

  // Drives one transaction from a negedge; returns at the negedge of the
  // IDLE cycle after the ack, so a following call is back-to-back.
  task automatic access(input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output obs_t o);
    o.nwait = 0;
    while (ready[s] !== 1'b1 && o.nwait < 50) begin
      @(negedge clk);
      o.nwait++;
    end
    req[s] = 1'b1; wr[s] = w; addr[s] = a; wdata[s] = d;
    @(negedge clk);
    req[s] = 1'b0; wr[s] = 1'($urandom); addr[s] = $urandom; wdata[s] = $urandom;
    o.lat = 1;
    while (ack[s] !== 1'b1 && o.lat < 40) begin
      @(negedge clk);
      o.lat++;
    end
    o.rd = rdata[s]; o.er = err[s]; o.rdy_ack = ready[s];
    @(negedge clk);
    o.ack_after = ack[s]; o.err_after = err[s]; o.rd_after = rdata[s];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; wr[s] = 1'b0; addr[s] = 32'd0; wdata[s] = 32'd0;
    end
    model_reset();
    #2;
    for (int s = 0; s < 2; s++) begin
      n_assert++;
      if (ready[s] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 1", s, ready[s]); end
      n_assert++;
      if (ack[s] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b expected 0", s, ack[s]); end
      n_assert++;
      if (err[s] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", s, err[s]); end
      n_assert++;
      if (rdata[s] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", s, rdata[s]); end
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    obs_t o; logic [31:0] e; logic ee; bit ek;
    model_step(1, 1'b1, 32'h10, 32'hDEADBEEF, e, ee, ek);
    access(1, 1'b1, 32'h10, 32'hDEADBEEF, o);
    n_assert++;
    if (o.lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", o.lat); end
    n_assert++;
    if (o.er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", o.er); end
    n_assert++;
    if (o.ack_after !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %b expected 0", o.ack_after); end
    model_step(1, 1'b0, 32'h10, 32'd0, e, ee, ek);
    access(1, 1'b0, 32'h10, 32'd0, o);
    n_assert++;
    if (o.rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", o.rd); end
    n_assert++;
    if (o.lat !== 3 || o.er !== 1'b0) begin n_fail++; $display("FAIL rd_lat_err: got lat %0d err %b expected 3 0", o.lat, o.er); end
    n_assert++;
    if (o.rd_after !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold: got %h expected deadbeef", o.rd_after); end
  endtask

  task automatic test_illegal();
    obs_t o; logic [31:0] e; logic ee; bit ek;
    model_step(1, 1'b1, 32'h0, 32'hA5A5_0001, e, ee, ek);
    access(1, 1'b1, 32'h0, 32'hA5A5_0001, o);
    model_step(1, 1'b0, 32'h12, 32'd0, e, ee, ek);
    access(1, 1'b0, 32'h12, 32'd0, o);
    n_assert++;
    if (o.er !== 1'b1 || o.rd !== 32'd0) begin n_fail++; $display("FAIL misaligned_rd: got err %b data %h expected 1 0", o.er, o.rd); end
    n_assert++;
    if (o.err_after !== 1'b0) begin n_fail++; $display("FAIL err_qualified: got %b expected 0", o.err_after); end
    model_step(1, 1'b1, 32'h100, 32'hBAD0_BAD0, e, ee, ek);
    access(1, 1'b1, 32'h100, 32'hBAD0_BAD0, o);
    n_assert++;
    if (o.er !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b expected 1", o.er); end
    model_step(1, 1'b0, 32'h0, 32'd0, e, ee, ek);
    access(1, 1'b0, 32'h0, 32'd0, o);
    n_assert++;
    if (o.rd !== 32'hA5A5_0001 || o.er !== 1'b0) begin n_fail++; $display("FAIL oor_no_alias: got %h err %b expected a5a50001 0", o.rd, o.er); end
  endtask

  task automatic test_ignore_during_wait();
    obs_t o; logic [31:0] e; logic ee; bit ek;
    int acks; int n;
    model_step(1, 1'b1, 32'h20, 32'h1111_2020, e, ee, ek);
    access(1, 1'b1, 32'h20, 32'h1111_2020, o);
    model_step(1, 1'b1, 32'h24, 32'h2222_2424, e, ee, ek);
    n = 0;
    while (ready[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h24; wdata[1] = 32'h2222_2424;
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hFFFF_0000;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (ack[1] === 1'b1) acks++;
      if (i == 2) req[1] = 1'b0;
      @(negedge clk);
    end
    n_assert++;
    if (acks !== 1) begin n_fail++; $display("FAIL wait_single_ack: got %0d expected 1", acks); end
    model_step(1, 1'b0, 32'h20, 32'd0, e, ee, ek);
    access(1, 1'b0, 32'h20, 32'd0, o);
    n_assert++;
    if (o.rd !== 32'h1111_2020) begin n_fail++; $display("FAIL wait_ignored_addr: got %h expected 11112020", o.rd); end
    model_step(1, 1'b0, 32'h24, 32'd0, e, ee, ek);
    access(1, 1'b0, 32'h24, 32'd0, o);
    n_assert++;
    if (o.rd !== 32'h2222_2424) begin n_fail++; $display("FAIL wait_accepted_addr: got %h expected 22222424", o.rd); end
  endtask

  task automatic test_lat0_back_to_back();
    obs_t o; logic [31:0] e; logic ee; bit ek;
    logic [31:0] d;
    d = $urandom;
    model_step(0, 1'b1, 32'h4, d, e, ee, ek);
    access(0, 1'b1, 32'h4, d, o);
    n_assert++;
    if (o.lat !== 1 || o.rdy_ack !== 1'b0) begin n_fail++; $display("FAIL l0_wr: got lat %0d ready %b expected 1 0", o.lat, o.rdy_ack); end
    model_step(0, 1'b0, 32'h4, 32'd0, e, ee, ek);
    access(0, 1'b0, 32'h4, 32'd0, o);
    n_assert++;
    if (o.nwait !== 0) begin n_fail++; $display("FAIL l0_ready_idle: got %0d wait cycles expected 0", o.nwait); end
    n_assert++;
    if (o.lat !== 1 || o.rdy_ack !== 1'b0) begin n_fail++; $display("FAIL l0_rd: got lat %0d ready %b expected 1 0", o.lat, o.rdy_ack); end
    n_assert++;
    if (o.rd !== d) begin n_fail++; $display("FAIL l0_rd_data: got %h expected %h", o.rd, d); end
  endtask

  task automatic test_reset_during_resp();
    obs_t o; logic [31:0] e; logic ee; bit ek;
    int n;
    model_step(1, 1'b1, 32'h8, 32'hCAFE_0008, e, ee, ek);
    access(1, 1'b1, 32'h8, 32'hCAFE_0008, o);
    n = 0;
    while (ready[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'h1234_5678;
    @(negedge clk);
    req[1] = 1'b0;
    n = 0;
    while (ack[1] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_assert++;
    if (ack[1] !== 1'b1) begin n_fail++; $display("FAIL rst_resp_reached: got %b expected 1", ack[1]); end
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin n_fail++; $display("FAIL rst_async_ack_err: got %b %b expected 0 0", ack[1], err[1]); end
    n_assert++;
    if (ready[1] !== 1'b1 || rdata[1] !== 32'd0) begin n_fail++; $display("FAIL rst_async_ready_data: got %b %h expected 1 0", ready[1], rdata[1]); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    model_step(1, 1'b0, 32'h8, 32'd0, e, ee, ek);
    access(1, 1'b0, 32'h8, 32'd0, o);
    n_assert++;
    if (o.rd !== 32'hCAFE_0008 || o.rd !== e) begin n_fail++; $display("FAIL rst_write_discarded: got %h expected cafe0008", o.rd); end
  endtask

  task automatic test_back_to_back();
    obs_t o; logic [31:0] e; logic ee; bit ek;
    logic [31:0] a [10];
    int base;
    base = int'($urandom_range(0, 63));
    for (int i = 0; i < 10; i++) begin
      a[i] = 32'((base + i * 7) % DEPTH) << 2;
      model_step(1, 1'b1, a[i], $urandom, e, ee, ek);
      access(1, 1'b1, a[i], mdl[1][a[i] >> 2], o);
      n_assert++;
      if (o.er !== 1'b0 || (i > 0 && o.nwait !== 0)) begin n_fail++; $display("FAIL burst_wr[%0d]: got err %b wait %0d expected 0 0", i, o.er, o.nwait); end
    end
    for (int i = 0; i < 10; i++) begin
      model_step(1, 1'b0, a[i], 32'd0, e, ee, ek);
      access(1, 1'b0, a[i], 32'd0, o);
      n_assert++;
      if (o.rd !== e || o.er !== 1'b0) begin n_fail++; $display("FAIL burst_rd[%0d]: got %h err %b expected %h 0", i, o.rd, o.er, e); end
    end
  endtask

  task automatic test_random_ops();
    obs_t o; logic [31:0] e; logic ee; bit ek;
    int s; logic w; logic [31:0] a; logic [31:0] d;
    for (int i = 0; i < 60; i++) begin
      s = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        2:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        default: a = 32'($urandom_range(DEPTH, 4000)) << 2;
      endcase
      model_step(s, w, a, d, e, ee, ek);
      access(s, w, a, d, o);
      n_assert++;
      if (o.er !== ee) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b addr %h", i, o.er, ee, a); end
      n_assert++;
      if (o.lat !== lat_of(s) + 1) begin n_fail++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", i, o.lat, lat_of(s) + 1); end
      n_assert++;
      if (o.ack_after !== 1'b0 || o.err_after !== 1'b0) begin n_fail++; $display("FAIL rnd_pulse[%0d]: got ack %b err %b expected 0 0", i, o.ack_after, o.err_after); end
      if (ek) begin
        n_assert++;
        if (o.rd !== e || o.rd_after !== e) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h/%h expected %h addr %h w %b", i, o.rd, o.rd_after, e, a, w); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_ignore_during_wait();
    test_lat0_back_to_back();
    test_reset_during_resp();
    test_back_to_back();
    test_random_ops();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
